miner_job_scheduler: RTL and testbench

Sequences the hashing cores on `hash_clk`. It latches each job delivered by `uart_comm` (`new_work`, midstate, work data, nonce range) and splits the nonce range into fixed-size chunks. Chunks go to idle cores in round-robin order. Golden nonces found by the cores are arbitrated back onto the single `new_golden_nonce`/`golden_nonce` pair that `uart_comm` reports to the host. It sits between `uart_comm` (after its clock-domain crossing) and the array of `NUM_CORES` SHA-256 cores.

---
 rtl/miner_job_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_miner_job_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_job_scheduler.sv
// Job scheduler for the hashing cores: latches jobs, splits the nonce range into
// fixed-size chunks handed round-robin to idle cores, and funnels found nonces back.
module miner_job_scheduler #(
   parameter int NUM_CORES  = 4,
   parameter int CHUNK_LOG2 = 24
) (
   input  logic                     hash_clk,
   input  logic                     rst_n,
   input  logic                     new_work,
   input  logic [255:0]             midstate,
   input  logic [95:0]              work_data,
   input  logic [31:0]              nonce_min,
   input  logic [31:0]              nonce_max,
   output logic [255:0]             job_midstate,
   output logic [95:0]              job_data,
   output logic [NUM_CORES-1:0]     core_start,
   output logic [31:0]              core_nonce_first,
   output logic [31:0]              core_nonce_last,
   output logic                     core_abort,
   input  logic [NUM_CORES-1:0]     core_busy,
   input  logic [NUM_CORES-1:0]     core_found,
   input  logic [32*NUM_CORES-1:0]  core_nonce,
   output logic                     new_golden_nonce,
   output logic [31:0]              golden_nonce,
   output logic                     need_work,
   output logic                     nonce_lost
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [32:0] CHUNK_M1 = 33'((33'd1 << CHUNK_LOG2) - 33'd1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DISPATCH,
      ST_DRAIN
   } state_t;

   state_t                        state_q, state_d;
   logic [255:0]                  midstate_q, midstate_d;
   logic [95:0]                   data_q, data_d;
   logic [31:0]                   next_q, next_d;
   logic [31:0]                   last_q, last_d;
   logic [IDX_W-1:0]              rr_q, rr_d;
   logic [IDX_W-1:0]              arb_q, arb_d;
   logic [NUM_CORES-1:0]          granted_q;
   logic                          abort_q, abort_d;
   logic                          need_work_q, need_work_d;
   logic                          lost_q, lost_d;
   logic [NUM_CORES-1:0]          full_q, full_d;
   logic [NUM_CORES-1:0][31:0]    latch_q, latch_d;

   logic [NUM_CORES-1:0]          start_c;
   logic [31:0]                   first_c, last_c;
   logic [32:0]                   chunk_end33;
   logic [31:0]                   chunk_end;
   logic [NUM_CORES-1:0]          grant_elig;
   logic [IDX_W:0]                grant_pick;
   logic [IDX_W:0]                arb_pick;
   logic                          emit;
   logic [31:0]                   golden_c;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      if (v == IDX_W'(NUM_CORES - 1)) return '0;
      return v + 1'b1;
   endfunction

   // Returns {hit, index} of the first requester at or after ptr.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] cand;
      logic [IDX_W-1:0] win;
      logic             hit;
      cand = ptr;
      win  = '0;
      hit  = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (!hit && req[cand]) begin
            hit = 1'b1;
            win = cand;
         end
         cand = wrap_inc(cand);
      end
      return {hit, win};
   endfunction

   // Chunk end is formed in 33 bits so a chunk reaching 0xFFFFFFFF cannot wrap.
   assign chunk_end33 = {1'b0, next_q} + CHUNK_M1;
   assign chunk_end   = (chunk_end33 > {1'b0, last_q}) ? last_q : chunk_end33[31:0];
   assign grant_elig  = ~core_busy & ~granted_q;
   assign grant_pick  = rr_pick(grant_elig, rr_q);

   always_comb begin
      state_d    = state_q;
      midstate_d = midstate_q;
      data_d     = data_q;
      next_d     = next_q;
      last_d     = last_q;
      rr_d       = rr_q;
      abort_d    = 1'b0;
      start_c    = '0;
      first_c    = '0;
      last_c     = '0;
      if (new_work) begin
         midstate_d = midstate;
         data_d     = work_data;
         next_d     = nonce_min;
         last_d     = nonce_max;
         abort_d    = 1'b1;
         state_d    = (nonce_min > nonce_max) ? ST_IDLE : ST_LOAD;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: state_d = ST_DISPATCH;
            ST_DISPATCH: begin
               if (grant_pick[IDX_W]) begin
                  start_c[grant_pick[IDX_W-1:0]] = 1'b1;
                  first_c = next_q;
                  last_c  = chunk_end;
                  rr_d    = wrap_inc(grant_pick[IDX_W-1:0]);
                  if (chunk_end == last_q) state_d = ST_DRAIN;
                  else next_d = chunk_end + 32'd1;
               end
            end
            ST_DRAIN: begin
               if (core_busy == '0 && granted_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      need_work_d = (state_d == ST_IDLE);
   end

   // Found-nonce latches; a new job flushes them and masks this cycle's finds.
   assign arb_pick = rr_pick(full_q, arb_q);
   assign emit     = arb_pick[IDX_W] && !new_work;
   assign golden_c = emit ? latch_q[arb_pick[IDX_W-1:0]] : 32'd0;

   always_comb begin
      full_d  = full_q;
      latch_d = latch_q;
      lost_d  = lost_q;
      arb_d   = arb_q;
      if (emit) arb_d = wrap_inc(arb_pick[IDX_W-1:0]);
      if (new_work) begin
         full_d = '0;
         lost_d = 1'b0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (core_found[i]) begin
               if (full_q[i] && !(emit && arb_pick[IDX_W-1:0] == IDX_W'(i))) begin
                  lost_d = 1'b1;
               end else begin
                  full_d[i]  = 1'b1;
                  latch_d[i] = core_nonce[32*i +: 32];
               end
            end else if (emit && arb_pick[IDX_W-1:0] == IDX_W'(i)) begin
               full_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         midstate_q  <= '0;
         data_q      <= '0;
         next_q      <= '0;
         last_q      <= '0;
         rr_q        <= '0;
         arb_q       <= '0;
         granted_q   <= '0;
         abort_q     <= 1'b0;
         need_work_q <= 1'b1;
         lost_q      <= 1'b0;
         full_q      <= '0;
         latch_q     <= '0;
      end else begin
         state_q     <= state_d;
         midstate_q  <= midstate_d;
         data_q      <= data_d;
         next_q      <= next_d;
         last_q      <= last_d;
         rr_q        <= rr_d;
         arb_q       <= arb_d;
         granted_q   <= start_c;
         abort_q     <= abort_d;
         need_work_q <= need_work_d;
         lost_q      <= lost_d;
         full_q      <= full_d;
         latch_q     <= latch_d;
      end
   end

   assign job_midstate     = midstate_q;
   assign job_data         = data_q;
   assign core_start       = start_c;
   assign core_nonce_first = first_c;
   assign core_nonce_last  = last_c;
   assign core_abort       = abort_q;
   assign new_golden_nonce = emit;
   assign golden_nonce     = golden_c;
   assign need_work        = need_work_q;
   assign nonce_lost       = lost_q;

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Directed bench for miner_job_scheduler with a simple busy-counter model of the cores.
module tb_miner_job_scheduler;

   localparam int NC = 4;
   localparam int CL = 24;

   logic                hash_clk = 1'b0;
   logic                rst_n;
   logic                new_work;
   logic [255:0]        midstate;
   logic [95:0]         work_data;
   logic [31:0]         nonce_min, nonce_max;
   logic [255:0]        job_midstate;
   logic [95:0]         job_data;
   logic [NC-1:0]       core_start;
   logic [31:0]         core_nonce_first, core_nonce_last;
   logic                core_abort;
   logic [NC-1:0]       core_busy;
   logic [NC-1:0]       core_found;
   logic [32*NC-1:0]    core_nonce;
   logic                new_golden_nonce;
   logic [31:0]         golden_nonce;
   logic                need_work;
   logic                nonce_lost;

   int                  n_checks = 0;
   int                  n_err = 0;
   logic [31:0]         exp_q[$];
   int                  busy_cnt[NC];
   int                  busy_len = 20;

   typedef struct {
      logic          nw;
      logic [31:0]   mn;
      logic [31:0]   mx;
      logic [NC-1:0] st;
      logic [31:0]   f;
      logic [31:0]   l;
      logic          ab;
      logic          need;
   } vec_t;
   vec_t tv[7];

   miner_job_scheduler #(.NUM_CORES(NC), .CHUNK_LOG2(CL)) dut (
      .hash_clk(hash_clk), .rst_n(rst_n), .new_work(new_work), .midstate(midstate),
      .work_data(work_data), .nonce_min(nonce_min), .nonce_max(nonce_max),
      .job_midstate(job_midstate), .job_data(job_data), .core_start(core_start),
      .core_nonce_first(core_nonce_first), .core_nonce_last(core_nonce_last),
      .core_abort(core_abort), .core_busy(core_busy), .core_found(core_found),
      .core_nonce(core_nonce), .new_golden_nonce(new_golden_nonce),
      .golden_nonce(golden_nonce), .need_work(need_work), .nonce_lost(nonce_lost)
   );

   // Clock / reset
   always #5 hash_clk = ~hash_clk;

   // Core model: busy from the cycle after start for busy_len cycles, cleared by abort.
   always @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NC; i++) busy_cnt[i] <= 0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            if (core_abort) busy_cnt[i] <= 0;
            else if (core_start[i]) busy_cnt[i] <= busy_len;
            else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
         end
      end
   end

   always_comb begin
      core_busy = '0;
      for (int i = 0; i < NC; i++) core_busy[i] = (busy_cnt[i] != 0);
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Advance to the drive point of the next cycle and clear one-cycle inputs.
   task automatic drive_edge();
      @(posedge hash_clk);
      #1;
      new_work   = 1'b0;
      core_found = '0;
   endtask

   // Sample point of the current cycle; golden-nonce scoreboard runs every cycle.
   task automatic settle();
      logic [31:0] e;
      @(negedge hash_clk);
      if (new_golden_nonce) begin
         if (exp_q.size() == 0) begin
            chk("golden_unexpected", {224'd0, golden_nonce}, 256'd0);
         end else begin
            e = exp_q.pop_front();
            chk("golden_value", {224'd0, golden_nonce}, {224'd0, e});
         end
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      new_work   = 1'b0;
      midstate   = '0;
      work_data  = '0;
      nonce_min  = '0;
      nonce_max  = '0;
      core_found = '0;
      core_nonce = '0;
      exp_q.delete();
      repeat (2) @(negedge hash_clk);
      rst_n = 1'b1;
   endtask

   task automatic start_job(input logic [31:0] mn, input logic [31:0] mx,
                            input logic [255:0] ms, input logic [95:0] wd);
      drive_edge();
      new_work  = 1'b1;
      nonce_min = mn;
      nonce_max = mx;
      midstate  = ms;
      work_data = wd;
      settle();
   endtask

   initial begin
      int rise;
      int starts;
      int aborts;
      int pulses;

      tv[0] = '{1'b1, 32'h0000_0000, 32'h02FF_FFFF, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1};
      tv[1] = '{1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
      tv[2] = '{1'b0, 32'h0, 32'h0, 4'b0001, 32'h0000_0000, 32'h00FF_FFFF, 1'b0, 1'b0};
      tv[3] = '{1'b0, 32'h0, 32'h0, 4'b0010, 32'h0100_0000, 32'h01FF_FFFF, 1'b0, 1'b0};
      tv[4] = '{1'b0, 32'h0, 32'h0, 4'b0100, 32'h0200_0000, 32'h02FF_FFFF, 1'b0, 1'b0};
      tv[5] = '{1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0};
      tv[6] = '{1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0};

      // 1. Reset values, then ten quiet cycles
      rst_n      = 1'b0;
      new_work   = 1'b0;
      midstate   = '0;
      work_data  = '0;
      nonce_min  = '0;
      nonce_max  = '0;
      core_found = '0;
      core_nonce = '0;
      repeat (3) @(negedge hash_clk);
      chk("rst_core_start", {252'd0, core_start}, 256'd0);
      chk("rst_first", {224'd0, core_nonce_first}, 256'd0);
      chk("rst_last", {224'd0, core_nonce_last}, 256'd0);
      chk("rst_abort", {255'd0, core_abort}, 256'd0);
      chk("rst_golden_pulse", {255'd0, new_golden_nonce}, 256'd0);
      chk("rst_golden", {224'd0, golden_nonce}, 256'd0);
      chk("rst_need_work", {255'd0, need_work}, 256'd1);
      chk("rst_lost", {255'd0, nonce_lost}, 256'd0);
      chk("rst_midstate", job_midstate, 256'd0);
      chk("rst_data", {160'd0, job_data}, 256'd0);
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         drive_edge();
         settle();
         if (core_start != '0 || core_abort || new_golden_nonce) pulses++;
      end
      chk("idle_pulses", 256'(pulses), 256'd0);
      chk("idle_need_work", {255'd0, need_work}, 256'd1);

      // 2. Normal dispatch, table driven for cycles 0..6
      do_reset();
      busy_len = 20;
      midstate  = 256'hA5A5;
      work_data = 96'h1234;
      for (int i = 0; i < 7; i++) begin
         drive_edge();
         new_work  = tv[i].nw;
         nonce_min = tv[i].mn;
         nonce_max = tv[i].mx;
         settle();
         chk($sformatf("t2_start[%0d]", i), {252'd0, core_start}, {252'd0, tv[i].st});
         chk($sformatf("t2_first[%0d]", i), {224'd0, core_nonce_first}, {224'd0, tv[i].f});
         chk($sformatf("t2_last[%0d]", i), {224'd0, core_nonce_last}, {224'd0, tv[i].l});
         chk($sformatf("t2_abort[%0d]", i), {255'd0, core_abort}, {255'd0, tv[i].ab});
         chk($sformatf("t2_need[%0d]", i), {255'd0, need_work}, {255'd0, tv[i].need});
      end
      rise = -1;
      starts = 0;
      for (int c = 7; c <= 40; c++) begin
         drive_edge();
         settle();
         if (core_start != '0) starts++;
         if (need_work && rise < 0) rise = c;
      end
      chk("t2_need_rise_cycle", 256'(rise), 256'd26);
      chk("t2_extra_starts", 256'(starts), 256'd0);

      // 3. Top-of-range chunk must not wrap
      do_reset();
      start_job(32'hFF00_0000, 32'hFFFF_FFFF, 256'hBEEF_0001, 96'hCAFE_0002);
      drive_edge();
      settle();
      chk("t3_abort", {255'd0, core_abort}, 256'd1);
      chk("t3_midstate", job_midstate, 256'hBEEF_0001);
      chk("t3_data", {160'd0, job_data}, 256'hCAFE_0002);
      drive_edge();
      settle();
      chk("t3_start", {252'd0, core_start}, 256'b0001);
      chk("t3_first", {224'd0, core_nonce_first}, 256'hFF00_0000);
      chk("t3_last", {224'd0, core_nonce_last}, 256'hFFFF_FFFF);
      rise = -1;
      starts = 0;
      for (int c = 3; c <= 35; c++) begin
         drive_edge();
         settle();
         if (core_start != '0) starts++;
         if (need_work && rise < 0) rise = c;
      end
      chk("t3_extra_starts", 256'(starts), 256'd0);
      chk("t3_need_rise_cycle", 256'(rise), 256'd24);

      // 4. Rejected job: abort only, need_work never drops
      do_reset();
      aborts = 0;
      starts = 0;
      pulses = 0;
      start_job(32'h1FFF_FFFF, 32'h0000_0000, 256'h77, 96'h88);
      if (!need_work) pulses++;
      for (int c = 1; c <= 6; c++) begin
         drive_edge();
         settle();
         if (c == 1) chk("t4_abort_c1", {255'd0, core_abort}, 256'd1);
         if (core_abort) aborts++;
         if (core_start != '0) starts++;
         if (!need_work) pulses++;
      end
      chk("t4_aborts", 256'(aborts), 256'd1);
      chk("t4_starts", 256'(starts), 256'd0);
      chk("t4_need_low_cycles", 256'(pulses), 256'd0);
      chk("t4_midstate", job_midstate, 256'h77);

      // 5. Nonce arbitration and loss
      do_reset();
      drive_edge();
      core_found = 4'b1010;
      core_nonce[32*1 +: 32] = 32'h38b9_b05a;
      core_nonce[32*3 +: 32] = 32'h1234_5678;
      exp_q.push_back(32'h38b9_b05a);
      exp_q.push_back(32'h1234_5678);
      settle();
      chk("t5_pulse_t0", {255'd0, new_golden_nonce}, 256'd0);
      drive_edge();
      settle();
      chk("t5_pulse_t1", {255'd0, new_golden_nonce}, 256'd1);
      chk("t5_nonce_t1", {224'd0, golden_nonce}, 256'h38b9_b05a);
      drive_edge();
      settle();
      chk("t5_pulse_t2", {255'd0, new_golden_nonce}, 256'd1);
      chk("t5_nonce_t2", {224'd0, golden_nonce}, 256'h1234_5678);
      drive_edge();
      settle();
      chk("t5_pulse_t3", {255'd0, new_golden_nonce}, 256'd0);
      drive_edge();
      core_found = 4'b0111;
      core_nonce[32*0 +: 32] = 32'hA000_0000;
      core_nonce[32*1 +: 32] = 32'hA111_1111;
      core_nonce[32*2 +: 32] = 32'hA222_2222;
      exp_q.push_back(32'hA000_0000);
      exp_q.push_back(32'hA111_1111);
      exp_q.push_back(32'hA222_2222);
      settle();
      drive_edge();
      core_found = 4'b0100;
      core_nonce[32*2 +: 32] = 32'hA2FF_FFFF;
      settle();
      chk("t5_lost_before", {255'd0, nonce_lost}, 256'd0);
      chk("t5_nonce_u1", {224'd0, golden_nonce}, 256'hA000_0000);
      drive_edge();
      settle();
      chk("t5_lost_set", {255'd0, nonce_lost}, 256'd1);
      chk("t5_nonce_u2", {224'd0, golden_nonce}, 256'hA111_1111);
      drive_edge();
      settle();
      chk("t5_nonce_u3", {224'd0, golden_nonce}, 256'hA222_2222);
      drive_edge();
      settle();
      chk("t5_pulse_u4", {255'd0, new_golden_nonce}, 256'd0);
      chk("t5_lost_sticky", {255'd0, nonce_lost}, 256'd1);
      start_job(32'h5, 32'h1, 256'h0, 96'h0);
      drive_edge();
      settle();
      chk("t5_lost_cleared", {255'd0, nonce_lost}, 256'd0);

      // 6. New work mid-dispatch flushes pending nonces and restarts the range
      do_reset();
      busy_len = 200;
      start_job(32'h0000_0000, 32'h0FFF_FFFF, 256'h1111, 96'h2222);
      for (int c = 1; c <= 6; c++) begin
         drive_edge();
         settle();
         if (c == 5) begin
            chk("t6_start_c5", {252'd0, core_start}, 256'b1000);
            chk("t6_first_c5", {224'd0, core_nonce_first}, 256'h0300_0000);
         end
         if (c == 6) chk("t6_start_c6", {252'd0, core_start}, 256'd0);
      end
      drive_edge();
      core_found = 4'b0111;
      core_nonce[32*0 +: 32] = 32'hD000_0000;
      core_nonce[32*1 +: 32] = 32'hD111_1111;
      core_nonce[32*2 +: 32] = 32'hD222_2222;
      settle();
      drive_edge();
      new_work  = 1'b1;
      nonce_min = 32'h4000_0000;
      nonce_max = 32'h4FFF_FFFF;
      midstate  = 256'h3333;
      work_data = 96'h4444;
      settle();
      chk("t6_pulse_c8", {255'd0, new_golden_nonce}, 256'd0);
      drive_edge();
      settle();
      chk("t6_abort_c9", {255'd0, core_abort}, 256'd1);
      chk("t6_pulse_c9", {255'd0, new_golden_nonce}, 256'd0);
      chk("t6_midstate", job_midstate, 256'h3333);
      drive_edge();
      settle();
      chk("t6_pulse_c10", {255'd0, new_golden_nonce}, 256'd0);
      chk("t6_start_c10", {252'd0, core_start}, 256'b0001);
      chk("t6_first_c10", {224'd0, core_nonce_first}, 256'h4000_0000);
      chk("t6_last_c10", {224'd0, core_nonce_last}, 256'h40FF_FFFF);
      drive_edge();
      settle();
      chk("t6_start_c11", {252'd0, core_start}, 256'b0010);
      chk("t6_first_c11", {224'd0, core_nonce_first}, 256'h4100_0000);

      chk("golden_queue_empty", 256'(exp_q.size()), 256'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
